ins_fetcher: RTL and testbench
==============================

Name: ins_fetcher

Overview:
- Front-end fetch stage, directly upstream of the branch predictor.
- Holds the architectural fetch PC and issues one instruction-cache request at a time.
- Presents each fetched word and its PC to the predictor, and takes the predicted next PC back.
- Pushes {ins, pc, pred_jump} into the instruction queue; ROB flushes redirect it and kill any in-flight fetch.

Parameters:
- ADDR_W, 32, address/PC width
- INS_W, 32, instruction width
- RESET_PC, 32'h0, PC loaded on reset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low = freeze
- icache_req_valid  out  1  fetch request, combinational from state
- icache_req_addr  out  ADDR_W  fetch address (= pc)
- icache_resp_valid  in  1  one-cycle pulse, word returned
- icache_resp_ins  in  INS_W  returned word
- pred_pc_cur  out  ADDR_W  PC of held instruction
- pred_ins_cur  out  INS_W  held instruction
- pred_pc_next  in  ADDR_W  predicted next PC (combinational)
- pred_jump  in  1  predicted taken
- iq_full  in  1  instruction queue cannot accept
- iq_valid  out  1  push pulse, registered
- iq_ins  out  INS_W  pushed instruction
- iq_pc  out  ADDR_W  pushed PC
- iq_pred_jump  out  1  prediction tag for ROB training
- rob_flush  in  1  mispredict/redirect
- rob_flush_pc  in  ADDR_W  redirect target

Behaviour:
- Reset (rst=0, async): state=S_REQ, pc=RESET_PC, ins_reg=0, all outputs 0 (icache_req_valid follows state and is gated by rdy).
- rdy=0: no register changes, icache_req_valid=0, iq_valid=0 next edge. The cache never completes while rdy=0.
- States:
  - S_REQ: icache_req_valid=1, addr=pc; next S_WAIT.
  - S_WAIT: on icache_resp_valid, ins_reg<=resp_ins, next S_OUT; else stay.
  - S_OUT: pred_* driven from {pc, ins_reg}. If !iq_full: iq_valid<=1, iq_ins<=ins_reg, iq_pc<=pc, iq_pred_jump<=pred_jump, pc<=pred_pc_next. Then next S_JALR if ins_reg[6:0]==7'b1100111, else S_REQ. If iq_full: hold, iq_valid<=0.
  - S_JALR: wait for rob_flush; no fetch.
  - S_DROP: wait for icache_resp_valid, discard the word, next S_REQ.
- pred_pc_cur/pred_ins_cur are driven continuously from pc/ins_reg; predictor outputs are sampled only in S_OUT.
- iq_valid is a 1-cycle pulse per push and is 0 in every other cycle.
- Latency with a 1-cycle cache: REQ c0, resp c1, OUT c2, iq_valid high c3 (same cycle as the next REQ). Throughput 1 instr / 3 cycles.
- rob_flush (highest priority, any state, rdy=1): pc<=rob_flush_pc, iq_valid<=0, and a push pending in S_OUT is cancelled. Next state:
  - S_DROP if a request is outstanding: state S_REQ, or S_WAIT without resp_valid this cycle, or already S_DROP.
  - S_REQ otherwise: S_WAIT with resp_valid same cycle (word discarded), S_OUT, or S_JALR.
- One outstanding request maximum; pc is never altered by an icache response.
- PC arithmetic wraps modulo 2^ADDR_W; no alignment check.

Decomposition:
- Shared define file: ADDR_WIDTH/INS_WIDTH ranges, OPCODE_JALR = 7'b1100111, state encoding constants (S_REQ, S_WAIT, S_OUT, S_JALR, S_DROP).
- No sub-module; single FSM plus datapath registers.

Test Plan:
- Reset: rst low mid-S_WAIT → state S_REQ, all outputs 0. After release, first icache_req_addr=0x0.
- Straight-line with 1-cycle cache (predictor returns pc+4): iq_pc sequence 0x0, 0x4, 0x8, with iq_valid pulses exactly 3 cycles apart and iq_ins matching the cache words.
- iq_full held high 5 cycles in S_OUT → no iq_valid and no new request. On release, iq_valid next edge with the same pc/ins.
- JALR at 0x10 (ins 0x000080E7) → pushed with iq_pc=0x10, then no requests. rob_flush with pc 0x200 → next request addr=0x200.
- rob_flush pc 0x80 in S_WAIT, response at +2 cycles → the response is not pushed, and the next request addr=0x80 only after the response pulse.
- rdy low 4 cycles during S_OUT with iq_full=0 → no push and pc unchanged. Push occurs on the first cycle after rdy rises.

Source files
------------

// File: rtl/ins_fetcher_pkg.sv
// Shared widths, opcode constants and FSM state encoding for the fetch stage.
package ins_fetcher_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INS_WIDTH  = 32;

  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_JALR = 3'd3,
    S_DROP = 3'd4
  } state_t;

  function automatic logic is_jalr(input logic [6:0] opcode);
    return (opcode == OPCODE_JALR);
  endfunction

endpackage

// File: rtl/ins_fetcher.sv
// Fetch stage: one outstanding I-cache request, hands each word to the branch
// predictor and pushes {ins, pc, pred_jump} into the instruction queue.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_WIDTH,
  parameter int                INS_W    = INS_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              icache_req_valid,
  output logic [ADDR_W-1:0] icache_req_addr,
  input  logic              icache_resp_valid,
  input  logic [INS_W-1:0]  icache_resp_ins,
  output logic [ADDR_W-1:0] pred_pc_cur,
  output logic [INS_W-1:0]  pred_ins_cur,
  input  logic [ADDR_W-1:0] pred_pc_next,
  input  logic              pred_jump,
  input  logic              iq_full,
  output logic              iq_valid,
  output logic [INS_W-1:0]  iq_ins,
  output logic [ADDR_W-1:0] iq_pc,
  output logic              iq_pred_jump,
  input  logic              rob_flush,
  input  logic [ADDR_W-1:0] rob_flush_pc
);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [INS_W-1:0]  ins_r, ins_nxt_s;
  logic              push_s;
  logic              iq_valid_r, iq_pred_jump_r;
  logic [INS_W-1:0]  iq_ins_r;
  logic [ADDR_W-1:0] iq_pc_r;

  assign icache_req_valid = rdy && (state_r == S_REQ);
  assign icache_req_addr  = pc_r;
  assign pred_pc_cur      = pc_r;
  assign pred_ins_cur     = ins_r;
  assign iq_valid         = iq_valid_r;
  assign iq_ins           = iq_ins_r;
  assign iq_pc            = iq_pc_r;
  assign iq_pred_jump     = iq_pred_jump_r;

  // Next-state, next-pc and push decision; a flush overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ins_nxt_s   = ins_r;
    push_s      = 1'b0;
    if (rob_flush) begin
      pc_nxt_s = rob_flush_pc;
      // A request still in flight must be drained before refetching.
      if ((state_r == S_REQ) || (state_r == S_DROP) ||
          ((state_r == S_WAIT) && !icache_resp_valid)) begin
        state_nxt_s = S_DROP;
      end else begin
        state_nxt_s = S_REQ;
      end
    end else begin
      case (state_r)
        S_REQ: state_nxt_s = S_WAIT;
        S_WAIT: begin
          if (icache_resp_valid) begin
            ins_nxt_s   = icache_resp_ins;
            state_nxt_s = S_OUT;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_OUT: begin
          if (!iq_full) begin
            push_s      = 1'b1;
            pc_nxt_s    = pred_pc_next;
            state_nxt_s = is_jalr(ins_r[6:0]) ? S_JALR : S_REQ;
          end else begin
            state_nxt_s = S_OUT;
          end
        end
        S_JALR: state_nxt_s = S_JALR;
        S_DROP: begin
          if (icache_resp_valid) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_DROP;
          end
        end
        default: state_nxt_s = S_REQ;
      endcase
    end
  end

  // FSM state register, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_REQ;
    end else if (rdy) begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC, held word and registered instruction-queue push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r           <= RESET_PC;
      ins_r          <= '0;
      iq_valid_r     <= 1'b0;
      iq_ins_r       <= '0;
      iq_pc_r        <= '0;
      iq_pred_jump_r <= 1'b0;
    end else if (rdy) begin
      pc_r       <= pc_nxt_s;
      ins_r      <= ins_nxt_s;
      iq_valid_r <= push_s;
      if (push_s) begin
        iq_ins_r       <= ins_r;
        iq_pc_r        <= pc_r;
        iq_pred_jump_r <= pred_jump;
      end
    end else begin
      iq_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ins_fetcher.sv
// Self-checking bench for ins_fetcher: directed scenarios plus randomized
// traffic against a transaction-level model of the fetch stream.
module tb_ins_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_ins;
  logic [31:0] pred_pc_cur, pred_ins_cur, pred_pc_next;
  logic        pred_jump;
  logic        iq_full;
  logic        iq_valid;
  logic [31:0] iq_ins, iq_pc;
  logic        iq_pred_jump;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  ins_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_ins(icache_resp_ins),
    .pred_pc_cur(pred_pc_cur), .pred_ins_cur(pred_ins_cur),
    .pred_pc_next(pred_pc_next), .pred_jump(pred_jump),
    .iq_full(iq_full), .iq_valid(iq_valid), .iq_ins(iq_ins), .iq_pc(iq_pc),
    .iq_pred_jump(iq_pred_jump),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side predictor and cache contents.
  logic pred_mode = 1'b0;
  logic rand_jalr = 1'b0;

  function automatic logic [31:0] exp_next(input logic [31:0] pc, input logic [31:0] w);
    if (pred_mode && w[13]) return pc + {24'd0, w[19:14], 2'b00};
    return pc + 32'd4;
  endfunction

  function automatic logic exp_jump(input logic [31:0] w);
    return pred_mode && w[13];
  endfunction

  assign pred_pc_next = exp_next(pred_pc_cur, pred_ins_cur);
  assign pred_jump    = exp_jump(pred_ins_cur);

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    if (a == 32'h10) return 32'h000080E7;
    if (rand_jalr && (w[22:20] == 3'b000)) return {w[31:7], 7'h67};
    return {w[31:7], 7'h13};
  endfunction

  // Stimulus knobs and model state.
  logic        rdy_d = 1'b0, full_d = 1'b0, flush_d = 1'b0;
  logic [31:0] flush_pc_d = 32'h0;
  int          lat_cfg = 1;

  logic [31:0] cur_pc;
  bit          outstanding, jalr_wait, last_rdy, last_full, last_flush, prev_iqv;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  bit          obs_push, obs_req;
  logic [31:0] obs_pc, obs_ins, obs_addr;
  int          n_push = 0;
  int          step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (step %0d)", name, act, exp, step_no);
    end
  endtask

  task automatic model_reset();
    cur_pc = 32'h0; outstanding = 0; jalr_wait = 0;
    last_rdy = 0; last_full = 0; last_flush = 0; prev_iqv = 0; pend = 0; pend_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
    chk("rst_iq_valid", {31'd0, iq_valid}, 32'd0);
    chk("rst_iq_pc", iq_pc, 32'h0);
    chk("rst_iq_ins", iq_ins, 32'h0);
    chk("rst_iq_pred_jump", {31'd0, iq_pred_jump}, 32'd0);
    chk("rst_pred_pc_cur", pred_pc_cur, 32'h0);
    chk("rst_pred_ins_cur", pred_ins_cur, 32'h0);
  endtask

  // One clock: observe the last edge, drive the next one, advance the model.
  task automatic step();
    logic [31:0] w;
    bit          resp_now;
    @(negedge clk);
    step_no++;
    obs_push = iq_valid; obs_pc = iq_pc; obs_ins = iq_ins;
    if (iq_valid) begin
      w = word_of(cur_pc);
      chk("push_gate", {29'd0, last_rdy, last_full, last_flush}, 32'd4);
      chk("push_pulse", {31'd0, prev_iqv}, 32'd0);
      chk("iq_pc", iq_pc, cur_pc);
      chk("iq_ins", iq_ins, w);
      chk("iq_pred_jump", {31'd0, iq_pred_jump}, {31'd0, exp_jump(w)});
      jalr_wait = (w[6:0] == 7'b1100111);
      cur_pc    = exp_next(cur_pc, w);
      n_push++;
    end
    prev_iqv = iq_valid;
    chk("pred_pc_cur", pred_pc_cur, cur_pc);

    rdy = rdy_d; iq_full = full_d; rob_flush = flush_d; rob_flush_pc = flush_pc_d;
    icache_resp_valid = 1'b0; icache_resp_ins = $urandom;
    resp_now = 0;
    if (pend && rdy_d) begin
      if (pend_cnt <= 1) begin
        icache_resp_valid = 1'b1;
        icache_resp_ins   = word_of(pend_addr);
        pend = 0; resp_now = 1;
      end else begin
        pend_cnt--;
      end
    end
    #1;
    obs_req = icache_req_valid; obs_addr = icache_req_addr;
    if (!rdy_d) begin
      chk("req_frozen", {31'd0, obs_req}, 32'd0);
    end else begin
      if (obs_req) begin
        chk("one_outstanding", {31'd0, outstanding}, 32'd0);
        chk("no_fetch_after_jalr", {31'd0, jalr_wait}, 32'd0);
        chk("req_addr", obs_addr, cur_pc);
      end
      if (resp_now) outstanding = 0;
      if (obs_req) begin
        outstanding = 1; pend = 1; pend_addr = obs_addr; pend_cnt = lat_cfg;
      end
      if (flush_d) begin
        cur_pc = flush_pc_d; jalr_wait = 0;
      end
    end
    last_rdy = rdy_d; last_full = full_d; last_flush = flush_d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] push_pcs [$];
    int          push_steps [$];
    bit          found;
    int          rand_push0;

    rst = 1'b0; rdy = 1'b0; iq_full = 1'b0; rob_flush = 1'b0; rob_flush_pc = 32'h0;
    icache_resp_valid = 1'b0; icache_resp_ins = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();

    // Reset asserted while a request is outstanding (S_WAIT).
    @(negedge clk) rst = 1'b1;
    rdy_d = 1'b1; lat_cfg = 3;
    step(); step();
    #2 rst = 1'b0; rdy = 1'b0; rdy_d = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk) rst = 1'b1;

    // Straight-line fetch with a 1-cycle cache, ending on the JALR at 0x10.
    lat_cfg = 1; rdy_d = 1'b1;
    step();
    chk("first_req_valid", {31'd0, obs_req}, 32'd1);
    chk("first_req_addr", obs_addr, 32'h0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (obs_push) begin
        push_pcs.push_back(obs_pc);
        push_steps.push_back(step_no);
        if (push_pcs.size() == 1) chk("first_push_ins", obs_ins, 32'h5A5A0013);
        if (obs_pc == 32'h10) begin
          found = 1;
          chk("jalr_push_ins", obs_ins, 32'h000080E7);
        end
      end
    end
    chk("jalr_reached", {31'd0, found}, 32'd1);
    if (push_pcs.size() >= 3) begin
      chk("seq_pc0", push_pcs[0], 32'h0);
      chk("seq_pc1", push_pcs[1], 32'h4);
      chk("seq_pc2", push_pcs[2], 32'h8);
      chk("seq_gap01", push_steps[1] - push_steps[0], 32'd3);
      chk("seq_gap12", push_steps[2] - push_steps[1], 32'd3);
    end else begin
      chk("seq_count", push_pcs.size(), 32'd3);
    end
    repeat (5) begin
      step();
      chk("jalr_idle", {31'd0, obs_req}, 32'd0);
    end

    // Redirect out of the JALR wait.
    flush_d = 1'b1; flush_pc_d = 32'h200;
    step();
    flush_d = 1'b0;
    step();
    chk("flush_req_valid", {31'd0, obs_req}, 32'd1);
    chk("flush_req_addr", obs_addr, 32'h200);

    // Queue full for five cycles while holding the word.
    step();
    full_d = 1'b1;
    repeat (5) begin
      step();
      chk("full_no_push", {31'd0, obs_push}, 32'd0);
      chk("full_no_req", {31'd0, obs_req}, 32'd0);
    end
    full_d = 1'b0;
    step();
    step();
    chk("full_release_push", {31'd0, obs_push}, 32'd1);
    chk("full_release_pc", obs_pc, 32'h200);
    chk("full_next_req", obs_addr, 32'h204);

    // Freeze for four cycles while the word is held.
    step();
    rdy_d = 1'b0;
    repeat (4) begin
      step();
      chk("freeze_no_push", {31'd0, obs_push}, 32'd0);
      chk("freeze_pc", pred_pc_cur, 32'h204);
    end
    rdy_d = 1'b1; lat_cfg = 3;
    step();
    step();
    chk("thaw_push", {31'd0, obs_push}, 32'd1);
    chk("thaw_push_pc", obs_pc, 32'h204);
    chk("thaw_req_addr", obs_addr, 32'h208);

    // Flush during S_WAIT; the late response must be dropped.
    flush_d = 1'b1; flush_pc_d = 32'h80;
    step();
    flush_d = 1'b0;
    step();
    chk("drop_wait1", {31'd0, obs_req}, 32'd0);
    step();
    chk("drop_wait2", {31'd0, obs_req}, 32'd0);
    lat_cfg = 1;
    step();
    chk("drop_req_valid", {31'd0, obs_req}, 32'd1);
    chk("drop_req_addr", obs_addr, 32'h80);
    step(); step(); step();
    chk("drop_push_pc", obs_pc, 32'h80);
    chk("drop_push_valid", {31'd0, obs_push}, 32'd1);

    // Randomized traffic with taken predictions and JALR stalls.
    pred_mode = 1'b1; rand_jalr = 1'b1;
    flush_d = 1'b1; flush_pc_d = 32'h1000;
    step();
    flush_d = 1'b0;
    rand_push0 = n_push;
    for (int i = 0; i < 3000; i++) begin
      rdy_d      = ($urandom_range(0, 99) < 88);
      full_d     = ($urandom_range(0, 99) < 25);
      flush_d    = rdy_d && ($urandom_range(0, 99) < (jalr_wait ? 30 : 3));
      flush_pc_d = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : $urandom;
      lat_cfg    = $urandom_range(1, 3);
      step();
    end
    chk("random_progress", {31'd0, (n_push - rand_push0) >= 50}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
